// File: rtl/sum_of_squares_pkg.sv
// Shared types and constants for the sum-of-squares frame accumulator.
//   sq_acc_state_t : FSM state encoding (IDLE, ACCUM, HOLD)
//   SQ_W           : width of an incoming square sample
//   SQ_MAX         : largest square the 3-bit generator can produce (7*7)
package sum_of_squares_pkg;

  localparam int unsigned SQ_W   = 6;
  localparam int unsigned SQ_MAX = 49;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } sq_acc_state_t;

endpackage

// File: rtl/sq_sat_add.sv
// Combinational ACC_W-bit adder: acc + zero-extended in_sq.
// Optional feature macro: SUM_OF_SQUARES_SAT_EN
//   defined   : result clamps at 2**ACC_W-1, ovf flags a clamped add
//   undefined : result wraps modulo 2**ACC_W, ovf is always 0
// Ports:
//   acc  in  ACC_W  current accumulator value
//   sq   in  SQ_W   sample to add
//   sum  out ACC_W  addition result
//   ovf  out 1      this addition overflowed (saturating build only)
module sq_sat_add
  import sum_of_squares_pkg::*;
#(
  parameter int unsigned ACC_W = 10
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [SQ_W-1:0]  sq,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

`ifdef SUM_OF_SQUARES_SAT_EN
  logic [ACC_W:0] full;

  always_comb begin
    full = {1'b0, acc} + (ACC_W + 1)'(sq);
    ovf  = full[ACC_W];
    sum  = ovf ? {ACC_W{1'b1}} : full[ACC_W-1:0];
  end
`else
  always_comb begin
    sum = acc + ACC_W'(sq);
    ovf = 1'b0;
  end
`endif

endmodule

// File: rtl/sum_of_squares_acc.sv
// Frame accumulator for 6-bit squares: sums FRAME_LEN accepted samples, tracks
// the frame maximum and holds the result until the consumer takes it.
// Optional feature macro: SUM_OF_SQUARES_SAT_EN (saturating add + sticky ovf).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous frame abort (ignored while holding a result)
//   in_valid/in_ready     sample handshake, in_sq carries the square
//   out_valid/out_ready   result handshake
//   out_sum/out_max/out_ovf  frame sum, frame maximum, saturation flag
module sum_of_squares_acc
  import sum_of_squares_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned ACC_W     = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SQ_W-1:0]  in_sq,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [SQ_W-1:0]  out_max,
  output logic             out_ovf
);

  localparam logic [7:0] LastCnt = 8'(FRAME_LEN);

  sq_acc_state_t    state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [SQ_W-1:0]  max_q, max_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic             xfer;

  sq_sat_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .acc (acc_q),
    .sq  (in_sq),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // in_ready depends only on state, never on in_valid.
  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign xfer      = in_valid & in_ready;

  // Result outputs come straight from the frame registers; they cannot move in
  // HOLD because nothing but out_ready or reset changes state there.
  assign out_sum = acc_q;
  assign out_max = max_q;
  assign out_ovf = ovf_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (flush) begin
          acc_d = '0;
          max_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (xfer) begin
          acc_d   = ACC_W'(in_sq);
          max_d   = in_sq;
          cnt_d   = 8'd1;
          ovf_d   = 1'b0;
          state_d = (LastCnt == 8'd1) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        // Flush beats a simultaneous transfer: the sample is dropped.
        if (flush) begin
          acc_d   = '0;
          max_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end else if (xfer) begin
          acc_d = add_sum;
          max_d = (in_sq > max_q) ? in_sq : max_q;
          cnt_d = cnt_q + 8'd1;
          ovf_d = ovf_q | add_ovf;
          if (cnt_q + 8'd1 == LastCnt) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          max_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sum_of_squares_acc.sv
// Directed bench for sum_of_squares_acc. A default instance (ACC_W=10) and a
// narrow instance (ACC_W=7) share all inputs and run in lockstep.
module tb_sum_of_squares_acc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic [5:0] in_sq;
  logic       out_ready;

  logic       in_ready, out_valid, out_ovf;
  logic [9:0] out_sum;
  logic [5:0] out_max;

  logic       w_in_ready, w_out_valid, w_out_ovf;
  logic [6:0] w_out_sum;
  logic [5:0] w_out_max;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int xfer_cnt  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) xfer_cnt <= xfer_cnt + 1;
  end

  sum_of_squares_acc #(
    .FRAME_LEN (8),
    .ACC_W     (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sq     (in_sq),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_max   (out_max),
    .out_ovf   (out_ovf)
  );

  sum_of_squares_acc #(
    .FRAME_LEN (8),
    .ACC_W     (7)
  ) dut_w (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (w_in_ready),
    .in_sq     (in_sq),
    .out_valid (w_out_valid),
    .out_ready (out_ready),
    .out_sum   (w_out_sum),
    .out_max   (w_out_max),
    .out_ovf   (w_out_ovf)
  );

  // Present one sample after 'gap' idle cycles; returns right after driving it.
  task automatic send(input logic [5:0] v, input int gap);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_sq    = v;
  endtask

  // Drop in_valid at the next negedge; results of the last edge are visible.
  task automatic settle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sq = '0; out_ready = 1'b1;
    #3;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_sum !== 10'd0 || out_max !== 6'd0 || out_ovf !== 1'b0)
      $display("FAIL reset_outputs got sum=%0d max=%0d ovf=%b want 0/0/0", out_sum, out_max, out_ovf);
      else pass_cnt++;
    total_cnt++; if (w_out_sum !== 7'd0 || w_out_valid !== 1'b0)
      $display("FAIL reset_narrow got sum=%0d valid=%b want 0/0", w_out_sum, w_out_valid); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [5:0] v [8];
    v = '{6'd0, 6'd1, 6'd4, 6'd9, 6'd16, 6'd25, 6'd36, 6'd49};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(v[i], 0);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid got %b want 0", out_valid); else pass_cnt++;
    settle();
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_sum !== 10'd140) $display("FAIL basic_sum got %0d want 140", out_sum); else pass_cnt++;
    total_cnt++; if (out_max !== 6'd49) $display("FAIL basic_max got %0d want 49", out_max); else pass_cnt++;
    total_cnt++; if (out_ovf !== 1'b0) $display("FAIL basic_ovf got %b want 0", out_ovf); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL basic_hold_ready got %b want 0", in_ready); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL basic_one_cycle got valid=%b ready=%b want 0/1", out_valid, in_ready); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [6:0] exp_sum;
    logic       exp_ovf;
`ifdef SUM_OF_SQUARES_SAT_EN
    exp_sum = 7'd127; exp_ovf = 1'b1;
`else
    exp_sum = 7'd8;   exp_ovf = 1'b0;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(6'd49, 0);
    settle();
    total_cnt++; if (out_sum !== 10'd392 || out_ovf !== 1'b0)
      $display("FAIL wide_sum got %0d/%b want 392/0", out_sum, out_ovf); else pass_cnt++;
    total_cnt++; if (w_out_valid !== 1'b1 || w_out_sum !== exp_sum)
      $display("FAIL narrow_sum got valid=%b sum=%0d want 1/%0d", w_out_valid, w_out_sum, exp_sum);
      else pass_cnt++;
    total_cnt++; if (w_out_ovf !== exp_ovf)
      $display("FAIL narrow_ovf got %b want %b", w_out_ovf, exp_ovf); else pass_cnt++;
    total_cnt++; if (w_out_max !== 6'd49) $display("FAIL narrow_max got %0d want 49", w_out_max); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(6'd2, 0);
    @(negedge clk);
    // Keep offering a sample while holding: it must not be taken.
    in_valid = 1'b1;
    in_sq    = 6'd49;
    for (int i = 0; i < 5; i++) begin
      total_cnt++; if (out_valid !== 1'b1 || out_sum !== 10'd16 || out_max !== 6'd2 || in_ready !== 1'b0)
        $display("FAIL bp_hold_%0d got valid=%b sum=%0d max=%0d ready=%b want 1/16/2/0",
                 i, out_valid, out_sum, out_max, in_ready);
        else pass_cnt++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    total_cnt++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL bp_accept_cycle got valid=%b ready=%b want 1/0", out_valid, in_ready); else pass_cnt++;
    @(negedge clk);
    in_valid = 1'b0;
    total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 10'd0)
      $display("FAIL bp_release got valid=%b ready=%b sum=%0d want 0/1/0", out_valid, in_ready, out_sum);
      else pass_cnt++;
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(6'd9, 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_sq    = 6'd9;
    flush    = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    total_cnt++; if (out_sum !== 10'd0 || out_max !== 6'd0 || in_ready !== 1'b1)
      $display("FAIL flush_clear got sum=%0d max=%0d ready=%b want 0/0/1", out_sum, out_max, in_ready);
      else pass_cnt++;
    for (int i = 0; i < 8; i++) send(6'd1, 0);
    settle();
    total_cnt++; if (out_valid !== 1'b1 || out_sum !== 10'd8 || out_max !== 6'd1)
      $display("FAIL flush_frame got valid=%b sum=%0d max=%0d want 1/8/1", out_valid, out_sum, out_max);
      else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_gaps();
    int x0;
    int waited;
    out_ready = 1'b1;
    x0 = xfer_cnt;
    for (int i = 0; i < 8; i++) send(6'd4, int'($urandom_range(0, 3)));
    settle();
    waited = 0;
    while (out_valid !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    total_cnt++; if (out_valid !== 1'b1 || out_sum !== 10'd32)
      $display("FAIL gaps_sum got valid=%b sum=%0d want 1/32", out_valid, out_sum); else pass_cnt++;
    total_cnt++; if (xfer_cnt - x0 !== 8)
      $display("FAIL gaps_xfers got %0d want 8", xfer_cnt - x0); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [5:0] v [8];
    v = '{6'd0, 6'd1, 6'd4, 6'd9, 6'd16, 6'd25, 6'd36, 6'd49};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(6'd16, 0);
    settle();
    rst_n = 1'b0;
    #1;
    total_cnt++; if (out_valid !== 1'b0 || out_sum !== 10'd0 || out_max !== 6'd0 || in_ready !== 1'b1)
      $display("FAIL rst_mid_frame got valid=%b sum=%0d max=%0d ready=%b want 0/0/0/1",
               out_valid, out_sum, out_max, in_ready);
      else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) send(6'd9, 0);
    settle();
    total_cnt++; if (out_valid !== 1'b1 || out_sum !== 10'd72 || out_max !== 6'd9)
      $display("FAIL rst_next_frame got valid=%b sum=%0d max=%0d want 1/72/9", out_valid, out_sum, out_max);
      else pass_cnt++;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(6'd1, 0);
    settle();
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL rst_hold_entry got %b want 1", out_valid); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (out_valid !== 1'b0 || out_sum !== 10'd0 || out_max !== 6'd0 || in_ready !== 1'b1)
      $display("FAIL rst_mid_hold got valid=%b sum=%0d max=%0d ready=%b want 0/0/0/1",
               out_valid, out_sum, out_max, in_ready);
      else pass_cnt++;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(v[i], 0);
    settle();
    total_cnt++; if (out_valid !== 1'b1 || out_sum !== 10'd140 || out_max !== 6'd49)
      $display("FAIL rst_after_hold got valid=%b sum=%0d max=%0d want 1/140/49", out_valid, out_sum, out_max);
      else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_flush();
    test_gaps();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sum_of_squares_acc.md
# sum_of_squares_acc

Downstream stage for the 3-bit square generator. It consumes one 6-bit square per valid/ready transfer and accumulates `FRAME_LEN` samples into a frame sum. It also tracks the largest square in the frame. Each finished frame result is held for a consumer with a valid/ready handshake.

## Interface
Parameters:
- `FRAME_LEN`, default 8: samples per frame, legal range 1..255.
- `ACC_W`, default 10: accumulator and `out_sum` width, legal range 6..16.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous frame abort.
- `in_valid`  in  1  `in_sq` carries a sample.
- `in_ready`  out  1  stage can accept a sample.
- `in_sq`  in  6  square value from the generator, bit 5 is MSB, range 0..49.
- `out_valid`  out  1  frame result available.
- `out_ready`  in  1  consumer takes the result.
- `out_sum`  out  `ACC_W`  sum of squares over the frame.
- `out_max`  out  6  largest `in_sq` in the frame.
- `out_ovf`  out  1  accumulator saturated during the frame.

## Operation
- FSM states: `IDLE`, `ACCUM`, `HOLD`.
- `in_ready = (state != HOLD)`. It is combinational, so it reads 1 while `rst_n` is low.
- A transfer happens on a cycle with `in_valid & in_ready`.
- `IDLE`, on a transfer:
  - load `acc = in_sq`, `max = in_sq`, `cnt = 1`.
  - go to `HOLD` if `FRAME_LEN == 1`, otherwise go to `ACCUM`.
- `ACCUM`, on a transfer:
  - `acc += in_sq`, `max = max(max, in_sq)`, `cnt += 1`.
  - when `cnt` reaches `FRAME_LEN`, go to `HOLD`.
- `ACCUM` without a transfer: hold all state. Gaps in `in_valid` are legal at any point.
- `HOLD`:
  - `out_valid = 1`; `out_sum`, `out_max`, `out_ovf` are driven from registers and stay stable.
  - when `out_ready` is high, go to `IDLE` and clear `acc`, `max`, `cnt`, `ovf`.
- `flush` high in `IDLE` or `ACCUM`: go to `IDLE` and clear `acc`, `max`, `cnt`, `ovf`.
- `flush` with a simultaneous transfer: flush wins and the sample is dropped.
- `flush` in `HOLD` is ignored. A completed result is never discarded.
- Arithmetic: `in_sq` is zero-extended to `ACC_W` before the add. Overflow behaviour is set by the macro in Configuration.
- Reset while `rst_n` is low:
  - state `IDLE`.
  - `acc`, `max`, `cnt`, `out_sum`, `out_max`, `out_ovf`, `out_valid` all 0.
  - reset mid-frame or mid-`HOLD` discards everything.

## Timing
- Results are registered. `out_valid` rises on the clock edge that accepts the `FRAME_LEN`-th sample.
- Input-to-result latency is 1 cycle after the last transfer.
- No back-to-back frame overlap: `in_ready` is 0 for every `HOLD` cycle, including the cycle in which `out_ready` is accepted.
- Peak throughput: one frame per `FRAME_LEN + 1` cycles.
- `out_valid` must not drop and outputs must not change until `out_ready` is sampled high.
- `in_ready` does not depend on `in_valid`, so there is no combinational path from input to `in_ready`.

## Configuration
- Macro: `SUM_OF_SQUARES_SAT_EN`.
- Defined:
  - additions clamp at `2**ACC_W - 1`.
  - `ovf` sets on the first clamped add and is sticky until the frame is cleared.
- Undefined:
  - additions wrap modulo `2**ACC_W`.
  - `out_ovf` is tied to 0.
- All ports exist in both builds.

## Structure
- Package `sum_of_squares_pkg` holds:
  - state enum `sq_acc_state_t` (`IDLE`, `ACCUM`, `HOLD`).
  - constant `SQ_W = 6`.
  - constant `SQ_MAX = 49`.
- One sub-module, `sq_sat_add`: a combinational `ACC_W`-bit adder taking `acc` and zero-extended `in_sq`. It returns the sum plus an overflow flag and contains the macro-controlled clamp.
- The FSM, counter and max tracker stay in the top module.

## Test plan
- Defaults, `in_sq` = 0,1,4,9,16,25,36,49 back-to-back, `out_ready = 1` -> `out_valid` for one cycle one cycle after the last sample; `out_sum = 140`, `out_max = 49`, `out_ovf = 0`.
- `ACC_W = 7`, eight samples of 49:
  - with `SUM_OF_SQUARES_SAT_EN` -> `out_sum = 127`, `out_ovf = 1`.
  - without it -> `out_sum = 8` (392 mod 128), `out_ovf = 0`.
- Backpressure: frame completes with `out_ready = 0` for 5 cycles -> `out_valid`, `out_sum`, `out_max` stable and `in_ready = 0` throughout; the frame is accepted on the cycle `out_ready = 1`, `in_ready = 1` the next cycle.
- Three samples of 9, then `flush` together with a fourth valid sample, then eight samples of 1 -> `out_sum = 8`, `out_max = 1`.
- Random `in_valid` gaps of 0..3 cycles across a frame of 4,4,4,4,4,4,4,4 -> `out_sum = 32`. A counter check confirms no sample is lost or repeated.
- `rst_n` pulsed low after 5 samples, and again during `HOLD` -> all outputs 0 immediately, `in_ready = 1`, next full frame correct.
